// File: rtl/ram_port_sched_pkg.sv
// Shared constants for the byte-wide RAM/IO port scheduler: size codes,
// requester (owner) codes, FSM states and read-data extension helpers.
package ram_port_sched_pkg;

    // Access sizes in bytes
    localparam logic [2:0] SZ_B = 3'd1;
    localparam logic [2:0] SZ_H = 3'd2;
    localparam logic [2:0] SZ_W = 3'd4;

    // Requester that currently owns the port
    localparam logic [1:0] OWN_FETCH = 2'd0;
    localparam logic [1:0] OWN_LOAD  = 2'd1;
    localparam logic [1:0] OWN_STORE = 2'd2;

    // addr[17:16] value that maps an access onto the IO space
    localparam logic [1:0] IO_SEL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_WRITE   = 2'd2,
        ST_IO_WAIT = 2'd3
    } state_e;

    // Anything that is not a byte or halfword is handled as a full word
    function automatic logic [2:0] norm_size(input logic [2:0] sz);
        logic [2:0] n;
        case (sz)
            SZ_B:    n = SZ_B;
            SZ_H:    n = SZ_H;
            default: n = SZ_W;
        endcase
        return n;
    endfunction

    // Zero- or sign-extend the low 8*n bits of an assembled read value
    function automatic logic [31:0] extend_read(input logic [31:0] raw,
                                                input logic [2:0]  n,
                                                input logic        sgn);
        logic [31:0] v;
        case (n)
            SZ_B:    v = sgn ? {{24{raw[7]}}, raw[7:0]}   : {24'd0, raw[7:0]};
            SZ_H:    v = sgn ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
            default: v = raw;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/ram_port_prio_arb.sv
// Fixed-priority grant for the RAM port: store > load > fetch.
// A flush hides the speculative requesters; the done bubble hides everyone.
module ram_port_prio_arb (
    input  logic       fetch_req,
    input  logic       load_req,
    input  logic       store_req,
    input  logic       in_flush,
    input  logic       bubble,
    output logic       grant,
    output logic [1:0] grant_owner
);
    import ram_port_sched_pkg::*;

    // Pick the highest-priority live requester, stores survive a flush
    always_comb begin
        grant       = 1'b0;
        grant_owner = OWN_FETCH;
        if (!bubble) begin
            if (store_req) begin
                grant       = 1'b1;
                grant_owner = OWN_STORE;
            end else if (!in_flush && load_req) begin
                grant       = 1'b1;
                grant_owner = OWN_LOAD;
            end else if (!in_flush && fetch_req) begin
                grant       = 1'b1;
                grant_owner = OWN_FETCH;
            end
        end
    end

endmodule

// File: rtl/ram_port_sched.sv
// Single-owner scheduler for the byte-wide RAM/IO port. Serialises 1/2/4 byte
// fetch/load/store accesses, assembles read data, aborts speculative reads on
// a flush and stalls IO writes while the UART buffer is full.
module ram_port_sched #(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_SEL = ram_port_sched_pkg::IO_SEL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_done,
    input  logic              load_req,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [2:0]        load_size,
    input  logic              load_signed,
    output logic              load_done,
    input  logic              store_req,
    input  logic [ADDR_W-1:0] store_addr,
    input  logic [2:0]        store_size,
    input  logic [31:0]       store_data,
    output logic              store_done,
    output logic [31:0]       rd_data,
    input  logic              in_flush,
    input  logic              io_buffer_full,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);
    import ram_port_sched_pkg::*;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [31:0]       data_q, data_d;
    logic [1:0]        owner_q, owner_d;
    logic [31:0]       bytes_q, bytes_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d;
    logic [31:0]       rd_data_q, rd_data_d;
    logic              fetch_done_q, fetch_done_d;
    logic              load_done_q, load_done_d;
    logic              store_done_q, store_done_d;

    logic              grant;
    logic [1:0]        grant_owner;
    logic              bubble;
    logic [ADDR_W-1:0] grant_addr;
    logic [2:0]        grant_size;
    logic [ADDR_W-1:0] issue_addr;
    logic              io_block;
    logic              rd_last;
    logic              wr_last;
    logic [31:0]       read_bytes;
    logic [7:0]        issue_byte;

    assign bubble = fetch_done_q | load_done_q | store_done_q;

    ram_port_prio_arb u_arb (
        .fetch_req   (fetch_req),
        .load_req    (load_req),
        .store_req   (store_req),
        .in_flush    (in_flush),
        .bubble      (bubble),
        .grant       (grant),
        .grant_owner (grant_owner)
    );

    // Decode the granted request and the write byte about to be issued.
    // In IDLE the candidate write is byte 0 of the incoming store; in
    // WRITE/IO_WAIT cnt_q is the index of the next byte still to be written,
    // while in READ it is the index of the byte arriving on mem_din.
    always_comb begin
        grant_addr = fetch_addr;
        grant_size = SZ_W;
        case (grant_owner)
            OWN_STORE: begin
                grant_addr = store_addr;
                grant_size = norm_size(store_size);
            end
            OWN_LOAD: begin
                grant_addr = load_addr;
                grant_size = norm_size(load_size);
            end
            default: begin
                grant_addr = fetch_addr;
                grant_size = SZ_W;
            end
        endcase
        issue_addr = (state_q == ST_IDLE) ? store_addr : addr_q + ADDR_W'(cnt_q);
        issue_byte = (state_q == ST_IDLE) ? store_data[7:0]
                                          : data_q[{cnt_q[1:0], 3'b000} +: 8];
        io_block   = (issue_addr[17:16] == IO_SEL) && io_buffer_full;
        rd_last    = ((cnt_q + 3'd1) == size_q);
        wr_last    = (cnt_q == size_q);
        read_bytes = bytes_q;
        read_bytes[{cnt_q[1:0], 3'b000} +: 8] = mem_din;
    end

    // State and datapath registers, frozen while rdy is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            addr_q       <= '0;
            size_q       <= 3'd0;
            signed_q     <= 1'b0;
            data_q       <= 32'd0;
            owner_q      <= OWN_FETCH;
            bytes_q      <= 32'd0;
            mem_a_q      <= '0;
            mem_dout_q   <= 8'd0;
            mem_wr_q     <= 1'b0;
            rd_data_q    <= 32'd0;
            fetch_done_q <= 1'b0;
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
        end else if (rdy) begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            data_q       <= data_d;
            owner_q      <= owner_d;
            bytes_q      <= bytes_d;
            mem_a_q      <= mem_a_d;
            mem_dout_q   <= mem_dout_d;
            mem_wr_q     <= mem_wr_d;
            rd_data_q    <= rd_data_d;
            fetch_done_q <= fetch_done_d;
            load_done_q  <= load_done_d;
            store_done_q <= store_done_d;
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    if (grant_owner == OWN_STORE) begin
                        state_d = io_block ? ST_IO_WAIT : ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (in_flush || rd_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (wr_last) begin
                    state_d = ST_IDLE;
                end else if (io_block) begin
                    state_d = ST_IO_WAIT;
                end
            end
            ST_IO_WAIT: begin
                if (!io_buffer_full) begin
                    state_d = ST_WRITE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs for the transition being taken
    always_comb begin
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        size_d       = size_q;
        signed_d     = signed_q;
        data_d       = data_q;
        owner_d      = owner_q;
        bytes_d      = bytes_q;
        mem_a_d      = mem_a_q;
        mem_dout_d   = mem_dout_q;
        mem_wr_d     = 1'b0;
        rd_data_d    = rd_data_q;
        fetch_done_d = 1'b0;
        load_done_d  = 1'b0;
        store_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    owner_d  = grant_owner;
                    addr_d   = grant_addr;
                    size_d   = grant_size;
                    signed_d = (grant_owner == OWN_LOAD) && load_signed;
                    data_d   = store_data;
                    bytes_d  = 32'd0;
                    mem_a_d  = grant_addr;
                    cnt_d    = 3'd0;
                    if ((grant_owner == OWN_STORE) && !io_block) begin
                        mem_dout_d = issue_byte;
                        mem_wr_d   = 1'b1;
                        cnt_d      = 3'd1;
                    end
                end
            end
            ST_READ: begin
                if (in_flush) begin
                    bytes_d = 32'd0;
                    cnt_d   = 3'd0;
                end else if (rd_last) begin
                    bytes_d      = read_bytes;
                    rd_data_d    = extend_read(read_bytes, size_q, signed_q);
                    fetch_done_d = (owner_q == OWN_FETCH);
                    load_done_d  = (owner_q == OWN_LOAD);
                    cnt_d        = 3'd0;
                end else begin
                    bytes_d = read_bytes;
                    cnt_d   = cnt_q + 3'd1;
                    mem_a_d = addr_q + ADDR_W'(cnt_q + 3'd1);
                end
            end
            ST_WRITE: begin
                if (wr_last) begin
                    store_done_d = 1'b1;
                    cnt_d        = 3'd0;
                end else if (!io_block) begin
                    mem_a_d    = issue_addr;
                    mem_dout_d = issue_byte;
                    mem_wr_d   = 1'b1;
                    cnt_d      = cnt_q + 3'd1;
                end
            end
            ST_IO_WAIT: begin
                if (!io_buffer_full) begin
                    mem_a_d    = issue_addr;
                    mem_dout_d = issue_byte;
                    mem_wr_d   = 1'b1;
                    cnt_d      = cnt_q + 3'd1;
                end
            end
            default: begin
                cnt_d = 3'd0;
            end
        endcase
    end

    assign mem_a      = mem_a_q;
    assign mem_dout   = mem_dout_q;
    assign mem_wr     = mem_wr_q;
    assign rd_data    = rd_data_q;
    assign fetch_done = fetch_done_q;
    assign load_done  = load_done_q;
    assign store_done = store_done_q;

endmodule
